// File: rtl/water_level_pkg.sv
// Shared types and width helpers for the tank pump controller.
package water_level_pkg;

  typedef enum logic [1:0] {
    StOff   = 2'd0,
    StRun   = 2'd1,
    StFault = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FaultNone    = 2'd0,
    FaultSensor  = 2'd1,
    FaultTimeout = 2'd2
  } fault_t;

  localparam int unsigned StateW = 2;
  localparam int unsigned FaultW = 2;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/level_debounce.sv
// One level sensor: 2-flop synchroniser followed by a consecutive-sample debouncer.
module level_debounce
  import water_level_pkg::*;
#(
  parameter int unsigned DEB_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic deb
);

  localparam int unsigned CW = cnt_w(DEB_CYC);
  localparam logic [CW-1:0] CntLast = CW'(DEB_CYC - 1);

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Any cycle where the synchronised bit agrees with the output restarts the window.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CntLast) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign deb = deb_q;

endmodule

// File: rtl/water_level_ctrl.sv
// Tank pump controller: debounced sensor column, thermometer decode, hysteresis FSM with
// minimum on/off times, sensor-fault and dry-run-timeout latching.
module water_level_ctrl
  import water_level_pkg::*;
#(
  parameter int unsigned N_SENS  = 4,
  parameter int unsigned LO_TH   = 1,
  parameter int unsigned HI_TH   = 3,
  parameter int unsigned DEB_CYC = 4,
  parameter int unsigned MIN_RUN = 8,
  parameter int unsigned MIN_OFF = 8,
  parameter int unsigned MAX_RUN = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [N_SENS-1:0]             lvl,
  input  logic                          fault_clr,
  output logic                          pump,
  output logic [$clog2(N_SENS+1)-1:0]   level,
  output logic                          fault,
  output logic [FaultW-1:0]             fault_code,
  output logic [StateW-1:0]             state
);

  localparam int unsigned LW = $clog2(N_SENS + 1);
  localparam int unsigned RW = cnt_w(MAX_RUN);
  localparam int unsigned OW = cnt_w(MIN_OFF);

  localparam logic [LW-1:0] LoLevel = LW'(LO_TH);
  localparam logic [LW-1:0] HiLevel = LW'(HI_TH);
  localparam logic [RW-1:0] RunLast = RW'(MAX_RUN - 1);
  localparam logic [RW-1:0] RunMin  = RW'(MIN_RUN - 1);
  localparam logic [OW-1:0] OffLast = OW'(MIN_OFF - 1);

  logic [N_SENS-1:0] deb_vec;
  logic              code_valid;
  logic [LW-1:0]     pop_cnt;
  logic [LW-1:0]     level_cur;
  logic [LW-1:0]     level_q;

  state_t        state_q, state_d;
  fault_t        fault_code_q, fault_code_d;
  logic          pump_q, pump_d;
  logic [RW-1:0] run_cnt_q, run_cnt_d;
  logic [OW-1:0] off_cnt_q, off_cnt_d;

  for (genvar g = 0; g < N_SENS; g++) begin : g_sens
    level_debounce #(
      .DEB_CYC (DEB_CYC)
    ) u_deb (
      .clk (clk),
      .rst (rst),
      .raw (lvl[g]),
      .deb (deb_vec[g])
    );
  end

  // A set bit above a clear bit cannot happen in a real tank.
  always_comb begin
    code_valid = 1'b1;
    pop_cnt    = '0;
    for (int i = 0; i < N_SENS; i++) begin
      pop_cnt = pop_cnt + LW'(deb_vec[i]);
      if (i > 0 && deb_vec[i] && !deb_vec[i-1]) begin
        code_valid = 1'b0;
      end
    end
    level_cur = code_valid ? pop_cnt : level_q;
  end

  always_comb begin
    state_d      = state_q;
    fault_code_d = fault_code_q;
    run_cnt_d    = run_cnt_q;
    off_cnt_d    = off_cnt_q;

    unique case (state_q)
      StOff: begin
        if (!code_valid) begin
          state_d      = StFault;
          fault_code_d = FaultSensor;
        end else if (en && level_cur <= LoLevel && off_cnt_q >= OffLast) begin
          state_d   = StRun;
          run_cnt_d = '0;
        end else if (off_cnt_q != OffLast) begin
          off_cnt_d = off_cnt_q + OW'(1);
        end
      end
      StRun: begin
        if (!code_valid) begin
          state_d      = StFault;
          fault_code_d = FaultSensor;
        end else if (run_cnt_q == RunLast) begin
          state_d      = StFault;
          fault_code_d = FaultTimeout;
        end else if (!en) begin
          state_d   = StOff;
          off_cnt_d = '0;
        end else if (level_cur >= HiLevel && run_cnt_q >= RunMin) begin
          state_d   = StOff;
          off_cnt_d = '0;
        end else begin
          run_cnt_d = run_cnt_q + RW'(1);
        end
      end
      StFault: begin
        if (fault_clr && code_valid) begin
          state_d      = StOff;
          fault_code_d = FaultNone;
          off_cnt_d    = '0;
        end
      end
      default: begin
        state_d      = StFault;
        fault_code_d = FaultSensor;
      end
    endcase

    pump_d = (state_d == StRun);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StOff;
      fault_code_q <= FaultNone;
      pump_q       <= 1'b0;
      run_cnt_q    <= '0;
      off_cnt_q    <= '0;
      level_q      <= '0;
    end else begin
      state_q      <= state_d;
      fault_code_q <= fault_code_d;
      pump_q       <= pump_d;
      run_cnt_q    <= run_cnt_d;
      off_cnt_q    <= off_cnt_d;
      level_q      <= level_cur;
    end
  end

  assign pump       = pump_q;
  assign level      = level_cur;
  assign fault      = (state_q == StFault);
  assign fault_code = fault_code_q;
  assign state      = state_q;

endmodule

// File: tb/tb_water_level_ctrl.sv
// Randomised bench for water_level_ctrl against a behavioural model of the control rules.
module tb_water_level_ctrl;

  localparam int N    = 4;
  localparam int LO   = 1;
  localparam int HI   = 3;
  localparam int DEB  = 4;
  localparam int MINR = 8;
  localparam int MINO = 8;
  localparam int MAXR = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [N-1:0] lvl;
  logic         fault_clr;
  logic         pump;
  logic [2:0]   level;
  logic         fault;
  logic [1:0]   fault_code;
  logic [1:0]   state;

  int checks   = 0;
  int failures = 0;

  water_level_ctrl #(
    .N_SENS  (N),
    .LO_TH   (LO),
    .HI_TH   (HI),
    .DEB_CYC (DEB),
    .MIN_RUN (MINR),
    .MIN_OFF (MINO),
    .MAX_RUN (MAXR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .lvl        (lvl),
    .fault_clr  (fault_clr),
    .pump       (pump),
    .level      (level),
    .fault      (fault),
    .fault_code (fault_code),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: raw -> two-sample delay -> accept when the last DEB synced samples all disagree.
  logic [N-1:0] m_s1, m_s2, m_deb;
  logic [N-1:0] m_hist[$];
  int m_last, m_st, m_code, m_run, m_off;

  function automatic logic [N-1:0] thermo(input int k);
    logic [N-1:0] t = '0;
    for (int i = 0; i < k; i++) t[i] = 1'b1;
    return t;
  endfunction

  function automatic bit m_valid();
    return thermo($countones(m_deb)) == m_deb;
  endfunction

  function automatic int m_level();
    return m_valid() ? $countones(m_deb) : m_last;
  endfunction

  task automatic model_reset();
    m_s1 = '0;
    m_s2 = '0;
    m_deb = '0;
    m_hist.delete();
    repeat (DEB) m_hist.push_back('0);
    m_last = 0;
    m_st = 0;
    m_code = 0;
    m_run = 0;
    m_off = 0;
  endtask

  task automatic model_step();
    bit           val;
    int           lev;
    logic [N-1:0] nd;
    val = m_valid();
    lev = m_level();
    m_hist.push_back(m_s2);
    void'(m_hist.pop_front());
    nd = m_deb;
    for (int b = 0; b < N; b++) begin
      bit all_diff = 1'b1;
      foreach (m_hist[k]) if (m_hist[k][b] == m_deb[b]) all_diff = 1'b0;
      if (all_diff) nd[b] = m_s2[b];
    end
    if (m_st != 2 && !val) begin
      m_st = 2; m_code = 1;
    end else if (m_st == 1 && m_run == MAXR - 1) begin
      m_st = 2; m_code = 2;
    end else if (m_st == 1 && !en) begin
      m_st = 0; m_off = 0;
    end else if (m_st == 1 && lev >= HI && m_run >= MINR - 1) begin
      m_st = 0; m_off = 0;
    end else if (m_st == 0 && en && lev <= LO && m_off >= MINO - 1) begin
      m_st = 1; m_run = 0;
    end else if (m_st == 2 && fault_clr && val) begin
      m_st = 0; m_code = 0; m_off = 0;
    end else if (m_st == 1) begin
      m_run++;
    end else if (m_st == 0) begin
      m_off++;
    end
    m_last = lev;
    m_s2 = m_s1;
    m_s1 = lvl;
    m_deb = nd;
  endtask

  task automatic compare_all();
    check_eq("pump", int'(pump), (m_st == 1) ? 1 : 0);
    check_eq("level", int'(level), m_level());
    check_eq("fault", int'(fault), (m_st == 2) ? 1 : 0);
    check_eq("fault_code", int'(fault_code), m_code);
    check_eq("state", int'(state), m_st);
  endtask

  task automatic cycle(input logic [N-1:0] v, input logic e, input logic clr);
    lvl = v;
    en = e;
    fault_clr = clr;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic async_reset();
    @(posedge clk);
    model_step();
    #2 rst = 1'b0;
    #1;
    check_eq("rst_pump", int'(pump), 0);
    check_eq("rst_state", int'(state), 0);
    check_eq("rst_fault", int'(fault), 0);
    check_eq("rst_code", int'(fault_code), 0);
    check_eq("rst_level", int'(level), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    compare_all();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] cur;
    logic [N-1:0] v;
    logic         e;
    int           kind;
    int           len;

    rst = 1'b0;
    en = 1'b0;
    lvl = '0;
    fault_clr = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    rst = 1'b1;

    // Empty tank with fill enabled: pump starts once the post-reset off time elapses.
    repeat (20) cycle('0, 1'b1, 1'b0);
    cur = '0;

    for (int seg = 0; seg < 300; seg++) begin
      kind = int'($urandom_range(0, 11));
      e = ($urandom_range(0, 7) != 0);
      if (kind <= 6) begin
        v = thermo(int'($urandom_range(0, N)));
        cur = v;
        len = int'($urandom_range(1, 20));
        for (int c = 0; c < len; c++) cycle(v, e, $urandom_range(0, 9) == 0);
      end else if (kind == 7) begin
        v = N'($urandom_range(0, (1 << N) - 1));
        cur = v;
        len = int'($urandom_range(5, 12));
        for (int c = 0; c < len; c++) cycle(v, e, $urandom_range(0, 9) == 0);
      end else if (kind == 8) begin
        v = cur;
        v[$urandom_range(0, N - 1)] ^= 1'b1;
        len = int'($urandom_range(1, 5));
        for (int c = 0; c < len; c++) cycle(v, e, 1'b0);
      end else if (kind == 9) begin
        cur = '0;
        for (int c = 0; c < 90; c++) cycle('0, 1'b1, 1'b0);
      end else if (kind == 10) begin
        async_reset();
      end else begin
        v = thermo(int'($urandom_range(0, N)));
        cur = v;
        for (int c = 0; c < 10; c++) cycle(v, e, 1'b0);
        cycle(v, e, 1'b1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/water_level_ctrl.md
# water_level_ctrl

Parametrised pump controller for a single tank with an N-point level-sensor column, replacing the two-sensor fill/stop cell. Each sensor is synchronised and debounced. The sensor vector is validated as a thermometer code and converted to a level count. The pump runs with hysteresis between configurable low and high thresholds, enforces minimum run and off times, and latches a fault on sensor inconsistency or dry-run timeout.

## Interface
- N_SENS, 4: number of level sensors; bit i set means water is at or above level i+1.
- LO_TH, 1: start filling when level ≤ LO_TH.
- HI_TH, 3: stop filling when level ≥ HI_TH. Constraint: 0 ≤ LO_TH < HI_TH ≤ N_SENS.
- DEB_CYC, 4: consecutive stable synchronised samples needed to accept a sensor change (≥1).
- MIN_RUN, 8: minimum pump-on cycles before a threshold stop.
- MIN_OFF, 8: minimum pump-off cycles before a start.
- MAX_RUN, 1024: run cycles after which a TIMEOUT fault is raised (> MIN_RUN).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- en  in  1  enables filling; low forces the pump off.
- lvl  in  N_SENS  raw level sensors, asynchronous.
- fault_clr  in  1  single-cycle pulse that clears a latched fault.
- pump  out  1  pump drive, registered.
- level  out  $clog2(N_SENS+1)  debounced level count, 0..N_SENS.
- fault  out  1  fault latched.
- fault_code  out  2  0 NONE, 1 SENSOR, 2 TIMEOUT.
- state  out  2  0 OFF, 1 RUN, 2 FAULT.

## Operation
- **Reset values:** pump=0, state=OFF, fault=0, fault_code=NONE. Debounced vector, level, run_cnt and off_cnt are all 0, so MIN_OFF is also enforced after reset.
- **Per-sensor conditioning:**
  - Each bit passes a 2-flop synchroniser.
  - The debounced bit takes the synchronised value once it has differed from the debounced bit for DEB_CYC consecutive cycles.
  - Any reversion inside that window restarts the count.
- **Level decode:**
  - Valid when the debounced vector is a thermometer code (no 1 above a 0).
  - level = popcount when valid; level holds its last valid value when invalid.
- **State transitions**, evaluated each cycle in priority order:
  1. Invalid code in OFF or RUN → FAULT, fault_code=SENSOR.
  2. RUN with run_cnt = MAX_RUN-1 → FAULT, fault_code=TIMEOUT.
  3. RUN with en=0 → OFF. This overrides MIN_RUN.
  4. RUN with level ≥ HI_TH and run_cnt ≥ MIN_RUN-1 → OFF.
  5. OFF with en=1, level ≤ LO_TH and off_cnt ≥ MIN_OFF-1 → RUN.
  6. FAULT with fault_clr=1 and valid code → OFF; fault and fault_code clear.
  - fault_clr while the code is still invalid has no effect.
  - fault_clr outside FAULT is ignored.
- **Counters:**
  - run_cnt counts cycles in RUN and clears on entry to RUN.
  - off_cnt counts cycles in OFF, saturates at MIN_OFF-1, and clears on entry to OFF.
  - Widths are $clog2 of MAX_RUN and MIN_OFF respectively.
- **Outputs:**
  - pump = (state==RUN), registered together with state.
  - In FAULT: pump=0 and fault=1.

## Timing
- A raw sensor edge held stable is reflected in level DEB_CYC+2 cycles after it is first sampled (2 synchroniser + DEB_CYC debounce).
- pump and state change on the edge after the qualifying condition is present: level→pump latency is 1 cycle.
- en falling while in RUN: pump=0 on the next edge.
- Minimum pulse widths:
  - A threshold stop gives pump high for ≥ MIN_RUN cycles.
  - A start gives pump low for ≥ MIN_OFF cycles.
- A fault raised in RUN drops pump on the same edge that sets fault.
- rst asserted mid-operation immediately forces all reset values, including pump=0. Release is synchronised by the system reset bridge.
- level exactly equal to LO_TH starts a fill; level exactly equal to HI_TH stops it.

## Structure
- Package water_level_pkg holds:
  - state_t enum (OFF, RUN, FAULT).
  - fault_t enum (NONE, SENSOR, TIMEOUT).
  - Width helper constants.
- Sub-module level_debounce (synchroniser plus debounce counter, parameter DEB_CYC) is instantiated N_SENS times.
- Decode, FSM and counters live in the top module.

## Test plan
Defaults apply, with MAX_RUN=64 for simulation.
- Reset, then en=1, lvl=0000: level=0 after 6 cycles; pump rises when off_cnt reaches 7; state=RUN.
- Fill: step lvl 0001→0011→0111 with each step held ≥10 cycles. pump falls 1 cycle after level=3 (MIN_RUN already met). Drain back to 0001: pump restarts after MIN_OFF.
- Glitch: a 3-cycle pulse on lvl[2] leaves level unchanged. A 4-cycle hold updates it.
- Sensor fault: lvl=0101 stable → fault=1, fault_code=1, pump=0. fault_clr while 0101: no change. lvl=0111 then fault_clr → state=OFF, fault=0.
- Timeout: lvl held 0000 with en=1 → after 64 RUN cycles fault_code=2, pump=0.
- Overrides:
  - en dropped 2 cycles into RUN: pump=0 next cycle.
  - rst pulsed low mid-RUN: pump=0 asynchronously; all outputs take reset values.
